// File: rtl/sd_to_twos_converter.sv
// rtl/sd_to_twos_converter.sv - on-the-fly signed-digit to two's-complement converter
module sd_to_twos_converter #(
    parameter int N_DIGITS = 8,
    parameter int CNT_W    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                digit_valid,
    input  logic                digit_first,
    input  logic [1:0]          digit_in,
    output logic [N_DIGITS:0]   result,
    output logic                result_valid,
    output logic                busy,
    output logic                frame_abort,
    output logic                stray_digit
);

    localparam int W = N_DIGITS + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [W-1:0]     q_reg, q_next;
    logic [W-1:0]     qm_reg, qm_next;
    logic [W-1:0]     result_next;
    logic             result_valid_next;
    logic             frame_abort_next;
    logic             stray_digit_next;

    // Digit decode and candidate Q/QM after applying the incoming digit
    logic             dig_pos, dig_neg;
    logic [W-1:0]     q_base, qm_base;
    logic [W-1:0]     q_shl, qm_shl;
    logic [W-1:0]     q_upd, qm_upd;
    logic [CNT_W-1:0] cnt_inc;

    assign busy = (state == ACCUM);

    // On-the-fly conversion step; a frame-start digit converts from a fresh Q=0/QM=-1 pair
    always_comb begin
        dig_pos = digit_in[1] & ~digit_in[0];
        dig_neg = digit_in[0] & ~digit_in[1];
        q_base  = digit_first ? '0 : q_reg;
        qm_base = digit_first ? '1 : qm_reg;
        q_shl   = q_base << 1;
        qm_shl  = qm_base << 1;
        q_upd   = q_shl;
        qm_upd  = qm_shl | W'(1);
        if (dig_pos) begin
            q_upd  = q_shl | W'(1);
            qm_upd = q_shl;
        end else if (dig_neg) begin
            q_upd  = qm_shl | W'(1);
            qm_upd = qm_shl;
        end
        cnt_inc = cnt + CNT_ONE;
    end

    // Next-state and registered-output logic for the IDLE/ACCUM frame tracker
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        q_next            = q_reg;
        qm_next           = qm_reg;
        result_next       = result;
        result_valid_next = 1'b0;
        frame_abort_next  = 1'b0;
        stray_digit_next  = 1'b0;
        if (digit_valid) begin
            case (state)
                IDLE: begin
                    if (digit_first) begin
                        q_next     = q_upd;
                        qm_next    = qm_upd;
                        cnt_next   = CNT_ONE;
                        state_next = ACCUM;
                    end else begin
                        stray_digit_next = 1'b1;
                    end
                end
                ACCUM: begin
                    q_next  = q_upd;
                    qm_next = qm_upd;
                    if (digit_first) begin
                        cnt_next         = CNT_ONE;
                        frame_abort_next = 1'b1;
                    end else if (cnt_inc == CNT_LAST) begin
                        cnt_next          = '0;
                        state_next        = IDLE;
                        result_next       = q_upd;
                        result_valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            q_reg        <= '0;
            qm_reg       <= '1;
            result       <= '0;
            result_valid <= 1'b0;
            frame_abort  <= 1'b0;
            stray_digit  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            q_reg        <= q_next;
            qm_reg       <= qm_next;
            result       <= result_next;
            result_valid <= result_valid_next;
            frame_abort  <= frame_abort_next;
            stray_digit  <= stray_digit_next;
        end
    end

endmodule
